// File: rtl/genius_video_pkg.sv
// Shared constants for the sprite pixel path: sprite indices, flag bits,
// pixel format and compositing priority.
package genius_video_pkg;

  localparam int unsigned NUM_SPRITES = 8;
  localparam int unsigned FLAGS_W     = 7;
  localparam int unsigned RGB_W       = 24;

  // Sprite indices match the SPRITES_EN / ROM slice bit positions
  localparam int unsigned SPR_PWR    = 0;
  localparam int unsigned SPR_WIN    = 1;
  localparam int unsigned SPR_LOSE   = 2;
  localparam int unsigned SPR_YELLOW = 3;
  localparam int unsigned SPR_RED    = 4;
  localparam int unsigned SPR_GREEN  = 5;
  localparam int unsigned SPR_BLUE   = 6;
  localparam int unsigned SPR_BG     = 7;

  localparam int unsigned FLG_BLUE   = 0;
  localparam int unsigned FLG_GREEN  = 1;
  localparam int unsigned FLG_RED    = 2;
  localparam int unsigned FLG_YELLOW = 3;
  localparam int unsigned FLG_LOSE   = 4;
  localparam int unsigned FLG_WIN    = 5;
  localparam int unsigned FLG_PWR    = 6;

  localparam logic [RGB_W-1:0] TRANSPARENT_KEY = 24'hFF00FF;

  // Highest priority first
  localparam int unsigned PRIO_ORDER [NUM_SPRITES] = '{
    SPR_WIN, SPR_LOSE, SPR_PWR, SPR_BLUE,
    SPR_GREEN, SPR_RED, SPR_YELLOW, SPR_BG
  };

endpackage

// File: rtl/sprite_addr_counter.sv
// Linear ROM read-address counter for one sprite: clear has priority over
// increment, and the count wraps naturally at 2^ADDR_W.
module sprite_addr_counter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sprite_pixel_mixer.sv
// Sprite ROM addressing, enable alignment and priority compositing for the
// VGA controller; also latches game visibility flags once per frame.
module sprite_pixel_mixer
  import genius_video_pkg::*;
#(
  parameter int unsigned      ADDR_W          = 17,
  parameter int unsigned      PIX_W           = 24,
  parameter int unsigned      ROM_LAT         = 1,
  parameter logic [PIX_W-1:0] TRANSPARENT_KEY = genius_video_pkg::TRANSPARENT_KEY,
  parameter logic [PIX_W-1:0] BG_COLOR        = '0
) (
  input  logic                            VGA_CLK,
  input  logic                            RESET_N,
  input  logic                            VGA_VS,
  input  logic [NUM_SPRITES-1:0]          SPRITES_EN,
  input  logic [FLAGS_W-1:0]              FLAGS_IN,
  output logic [FLAGS_W-1:0]              SPRITES_FLAGS,
  output logic [NUM_SPRITES*ADDR_W-1:0]   ROM_ADDR,
  input  logic [NUM_SPRITES*PIX_W-1:0]    ROM_DATA,
  output logic [RGB_W-1:0]                RGB
);

  logic                   vs_prev;
  logic                   frame_start;
  logic [NUM_SPRITES-1:0] en_pipe [ROM_LAT];
  logic [NUM_SPRITES-1:0] en_d;
  logic [NUM_SPRITES-1:0] opaque;
  logic [RGB_W-1:0]       pix_next;

  // Falling edge of VS: registered history against the live input, so the
  // counters clear on the same edge that sees VS go low.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_prev <= 1'b1;
    end else begin
      vs_prev <= VGA_VS;
    end
  end

  assign frame_start = vs_prev & ~VGA_VS;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SPRITES_FLAGS <= '0;
    end else if (frame_start) begin
      SPRITES_FLAGS <= FLAGS_IN;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cnt
    sprite_addr_counter #(
      .ADDR_W(ADDR_W)
    ) u_cnt (
      .clk  (VGA_CLK),
      .rst_n(RESET_N),
      .clr  (frame_start),
      .inc  (SPRITES_EN[g]),
      .count(ROM_ADDR[g*ADDR_W +: ADDR_W])
    );
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        en_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0] <= SPRITES_EN;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        en_pipe[i] <= en_pipe[i-1];
      end
    end
  end

  assign en_d = en_pipe[ROM_LAT-1];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_opq
    assign opaque[g] = en_d[g] && (ROM_DATA[g*PIX_W +: PIX_W] != TRANSPARENT_KEY);
  end

  // Walk from lowest to highest priority so the last opaque layer seen wins
  always_comb begin
    pix_next = BG_COLOR;
    for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
      if (opaque[PRIO_ORDER[NUM_SPRITES-1-k]]) begin
        pix_next = ROM_DATA[PRIO_ORDER[NUM_SPRITES-1-k]*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RGB <= '0;
    end else begin
      RGB <= pix_next;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_mixer.sv
// Directed checks for sprite_pixel_mixer: reset, flag latching, addressing,
// priority compositing, counter wrap, frame-start clear and async reset.
module tb_sprite_pixel_mixer;

  localparam int unsigned AW  = 17;
  localparam int unsigned PW  = 24;
  localparam int unsigned AWS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vs;
  logic [7:0]       en;
  logic [6:0]       flags_in;
  logic [6:0]       flags;
  logic [8*AW-1:0]  rom_addr;
  logic [8*PW-1:0]  rom_data;
  logic [23:0]      rgb;

  logic             vs_w = 1'b1;
  logic [7:0]       en_w;
  logic [6:0]       flags_in_w = '0;
  logic [6:0]       flags_w;
  logic [8*AWS-1:0] addr_w;
  logic [8*PW-1:0]  rom_data_w = '0;
  logic [23:0]      rgb_w;

  logic             addr_mode;
  logic [7:0]       key;
  logic [23:0]      const_val [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_pixel_mixer #(
    .ADDR_W(AW), .PIX_W(PW), .ROM_LAT(1)
  ) dut (
    .VGA_CLK(clk), .RESET_N(rst_n), .VGA_VS(vs), .SPRITES_EN(en),
    .FLAGS_IN(flags_in), .SPRITES_FLAGS(flags), .ROM_ADDR(rom_addr),
    .ROM_DATA(rom_data), .RGB(rgb)
  );

  sprite_pixel_mixer #(
    .ADDR_W(AWS), .PIX_W(PW), .ROM_LAT(1)
  ) dut_w (
    .VGA_CLK(clk), .RESET_N(rst_n), .VGA_VS(vs_w), .SPRITES_EN(en_w),
    .FLAGS_IN(flags_in_w), .SPRITES_FLAGS(flags_w), .ROM_ADDR(addr_w),
    .ROM_DATA(rom_data_w), .RGB(rgb_w)
  );

  // One-cycle ROM model: word = address, or a per-sprite constant / key
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (addr_mode) rom_data[i*PW +: PW] <= PW'(rom_addr[i*AW +: AW]);
      else           rom_data[i*PW +: PW] <= key[i] ? 24'hFF00FF : const_val[i];
    end
  end

  typedef struct {
    logic [7:0]  en;
    logic [7:0]  key;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'(rom_addr[i*AW +: AW]);
  endfunction

  initial begin
    const_val[0] = 24'h0A0A0A; const_val[1] = 24'h445566;
    const_val[2] = 24'h202020; const_val[3] = 24'h303030;
    const_val[4] = 24'h404040; const_val[5] = 24'h505050;
    const_val[6] = 24'h606060; const_val[7] = 24'h112233;

    vecs[0]  = '{8'h82, 8'h00, 24'h445566};
    vecs[1]  = '{8'h82, 8'h02, 24'h112233};
    vecs[2]  = '{8'h00, 8'h00, 24'h000000};
    vecs[3]  = '{8'h08, 8'h08, 24'h000000};
    vecs[4]  = '{8'h88, 8'h08, 24'h112233};
    vecs[5]  = '{8'hFF, 8'h00, 24'h445566};
    vecs[6]  = '{8'hFD, 8'h00, 24'h202020};
    vecs[7]  = '{8'hF9, 8'h00, 24'h0A0A0A};
    vecs[8]  = '{8'hF8, 8'h00, 24'h606060};
    vecs[9]  = '{8'hB8, 8'h00, 24'h505050};
    vecs[10] = '{8'h98, 8'h00, 24'h404040};
    vecs[11] = '{8'h88, 8'h00, 24'h303030};
    vecs[12] = '{8'hFF, 8'hFE, 24'h0A0A0A};
    vecs[13] = '{8'hFF, 8'hFF, 24'h000000};

    rst_n = 1'b0; vs = 1'b1; en = '0; flags_in = '0; en_w = '0;
    addr_mode = 1'b1; key = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_flags", 32'(flags), 32'h0);
    for (int i = 0; i < 8; i++) check($sformatf("reset_addr%0d", i), addr_of(i), 32'h0);

    flags_in = 7'h41; vs = 1'b0;
    step(); step();
    check("flags_latch", 32'(flags), 32'h41);
    vs = 1'b1; flags_in = 7'h00;
    repeat (3) step();
    check("flags_hold", 32'(flags), 32'h41);

    // Background stepping, data = address
    for (int c = 0; c < 8; c++) begin
      check($sformatf("bg_addr_c%0d", c), addr_of(7), 32'((c < 5) ? c : 5));
      if (c >= 2 && c <= 6) check($sformatf("bg_rgb_c%0d", c), 32'(rgb), 32'(c - 2));
      if (c == 7) check("bg_rgb_idle", 32'(rgb), 32'h0);
      en = (c < 5) ? 8'h80 : 8'h00;
      step();
    end

    en = 8'h40;
    repeat (3) step();
    check("blue_cnt3", addr_of(6), 32'd3);
    vs = 1'b0;
    step();
    check("fs_clear_wins", addr_of(6), 32'd0);
    check("fs_clear_bg", addr_of(7), 32'd0);
    step();
    check("fs_then_inc", addr_of(6), 32'd1);
    en = 8'h00; vs = 1'b1;
    step();

    addr_mode = 1'b0;
    for (int v = 0; v < 14; v++) begin
      en = vecs[v].en; key = vecs[v].key;
      repeat (3) step();
      check($sformatf("mux_v%0d", v), 32'(rgb), 32'(vecs[v].exp_rgb));
    end
    en = '0; key = '0;

    en_w = 8'h01;
    repeat (15) step();
    check("wrap_top", 32'(addr_w[0 +: AWS]), 32'd15);
    step();
    check("wrap_zero", 32'(addr_w[0 +: AWS]), 32'd0);
    en_w = '0;

    addr_mode = 1'b1; en = 8'hFF;
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    check("async_rgb", 32'(rgb), 32'h0);
    check("async_flags", 32'(flags), 32'h0);
    for (int i = 0; i < 8; i++) check($sformatf("async_addr%0d", i), addr_of(i), 32'h0);
    en = '0;
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
